exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
Execute-stage datapath slice of the 9-bit-instruction accumulator-style core. It holds three pieces:
- A combinational 8-bit ALU with zero, parity and single-bit outputs.
- A 1-bit carry/bit storage register that feeds back into the ALU as the shift/carry input.
- An 8-bit address counter, loaded from the ALU result or incremented, that supplies the data-memory address.
It sits between the register-file/operand muxes and data memory, and is driven by the control decoder.

Parameters:
W, 8, data width of operands, result and counter.

Ports:
Clk  input  1  system clock, posedge.
Reset  input  1  synchronous, active-high; clears counter and bit storage.
InputA  input  W  ALU operand A (register or counter value, muxed upstream).
InputB  input  W  ALU operand B (register, immediate or LUT value, muxed upstream).
imm  input  3  bit index for GETB/SETB.
AluOp  input  4  ALU operation select.
ScSel  input  1  1 = ALU carry-in forced 0; 0 = carry-in is stored bit.
BitWrEn  input  1  bit storage write enable.
BitSel  input  2  bit storage source: 01 = Parity, 10 = OutBit, 00/11 = constant 0.
CtrWrEn  input  1  load counter with ALU result.
CtrInc  input  1  increment counter.
Out  output  W  ALU result (combinational).
Zero  output  1  Out == 0.
Parity  output  1  XOR-reduction of Out.
OutBit  output  1  op-specific bit result.
CtrOut  output  W  counter value (data-memory address).
BitOut  output  1  stored bit.

Behaviour:
- Carry-in: SC = ScSel ? 0 : BitOut.
- ALU is purely combinational and zero-latency. Arithmetic is mod 2^W. OutBit is 0 unless stated below.
  - 0000 ADD: Out=A+B+SC; OutBit=carry-out.
  - 0001 SUB: Out=A-B; OutBit=borrow (A<B unsigned).
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 NOT: Out=~A.
  - 0110 SHL: Out={A[6:0],SC}; OutBit=A[7].
  - 0111 SHR: Out={SC,A[7:1]}; OutBit=A[0].
  - 1000 GETB: Out=A; OutBit=A[imm].
  - 1001 SETB: Out=A with bit imm replaced by SC; OutBit=SC.
  - 1010 PASSB: Out=B.
  - 1011 INC: Out=A+1; OutBit=carry (A==8'hFF).
  - 1100..1111: reserved; Out=A, OutBit=0.
- Zero and Parity always derive from the final Out, for every op.
- Bit storage: on posedge Clk, Reset → 0. Otherwise, if BitWrEn, it loads the BitSel-selected value. Otherwise it holds.
- Counter: on posedge Clk, Reset → 0. Else if CtrWrEn, it loads Out. Else if CtrInc, it becomes CtrOut+1, wrapping 8'hFF→8'h00. Else it holds.
- Load has priority over increment when both are asserted.
- Reset wins over every enable.
- Reset values: CtrOut=0, BitOut=0. Combinational outputs follow inputs during reset, using SC=0 when ScSel=0 because BitOut=0.
- Same-cycle feedback: the bit written this cycle is visible as SC only from the next cycle; there is no bypass.
- A counter write uses the Out value present in the same cycle, which may itself depend on the old CtrOut via InputA.
- No X propagation from reserved op codes; all outputs are fully defined.

Decomposition:
- Shared package exec_pkg holds:
  - the AluOp enum (ADD..INC, reserved);
  - the BitSel enum (BIT_ZERO=00, BIT_PARITY=01, BIT_OUTBIT=10);
  - the W default.
- One sub-module, alu_core: combinational ALU producing Out/Zero/Parity/OutBit.
- Bit storage, counter and the BitSel/ScSel muxes stay in exec_unit.

Test Plan:
- Reset high 1 cycle with CtrWrEn=BitWrEn=1 → CtrOut=0, BitOut=0 after the edge.
- ADD A=8'hF0 B=8'h20 with stored bit=1, ScSel=0 → Out=8'h11, OutBit=1, Zero=0, Parity=0. Same with ScSel=1 → Out=8'h10.
- SUB A=5 B=5 → Out=0, Zero=1, Parity=0, OutBit=0. A=3 B=5 → Out=8'hFE, OutBit=1.
- GETB A=8'b0010_0000 imm=5, BitSel=10, BitWrEn=1 → BitOut=1 next cycle. Then SHL A=8'h81 → Out=8'h03, OutBit=1.
- XOR A=8'h0F B=8'h01, BitSel=01, BitWrEn=1 → Out=8'h0E, Parity=1, BitOut=1 next cycle. BitSel=00 → BitOut=0.
- Counter: load 8'hFE via PASSB with CtrWrEn → CtrOut=FE; CtrInc twice → FF then 00. CtrWrEn and CtrInc together with Out=8'h10 → CtrOut=8'h10.

Source files
------------

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// exec_pkg : shared types and width default for the execute-stage slice
// Revision : 1.0
// ============================================================================
package exec_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_NOT   = 4'b0101,
        ALU_SHL   = 4'b0110,
        ALU_SHR   = 4'b0111,
        ALU_GETB  = 4'b1000,
        ALU_SETB  = 4'b1001,
        ALU_PASSB = 4'b1010,
        ALU_INC   = 4'b1011,
        ALU_RSV0  = 4'b1100,
        ALU_RSV1  = 4'b1101,
        ALU_RSV2  = 4'b1110,
        ALU_RSV3  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        BIT_ZERO   = 2'b00,
        BIT_PARITY = 2'b01,
        BIT_OUTBIT = 2'b10,
        BIT_RSV    = 2'b11
    } bit_sel_e;

endpackage : exec_pkg
`default_nettype wire

// File: rtl/exec_if.sv
`default_nettype none
// ============================================================================
// exec_if : control/operand inputs and result outputs of the execute slice
// Revision : 1.0
// ============================================================================
interface exec_if
    import exec_pkg::*;
#(
    parameter int W = DATA_W
) ();
    logic [W-1:0] InputA;
    logic [W-1:0] InputB;
    logic [2:0]   imm;
    logic [3:0]   AluOp;
    logic         ScSel;
    logic         BitWrEn;
    logic [1:0]   BitSel;
    logic         CtrWrEn;
    logic         CtrInc;
    logic [W-1:0] Out;
    logic         Zero;
    logic         Parity;
    logic         OutBit;
    logic [W-1:0] CtrOut;
    logic         BitOut;

    modport master (
        output InputA, InputB, imm, AluOp, ScSel, BitWrEn, BitSel, CtrWrEn, CtrInc,
        input  Out, Zero, Parity, OutBit, CtrOut, BitOut
    );

    modport slave (
        input  InputA, InputB, imm, AluOp, ScSel, BitWrEn, BitSel, CtrWrEn, CtrInc,
        output Out, Zero, Parity, OutBit, CtrOut, BitOut
    );
endinterface : exec_if
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// alu_core : zero-latency ALU with zero, parity and op-specific bit outputs
// Revision : 1.0
// ============================================================================
module alu_core
    import exec_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  wire logic [W-1:0] a,
    input  wire logic [W-1:0] b,
    input  wire logic [2:0]   imm,
    input  wire logic [3:0]   op,
    input  wire logic         sc,
    output logic      [W-1:0] out,
    output logic              zero,
    output logic              parity,
    output logic              out_bit
);

    logic [W:0]   w_wide;
    logic [W-1:0] w_res;
    logic         w_bit;

    always_comb begin
        w_wide = '0;
        w_res  = a;
        w_bit  = 1'b0;
        case (alu_op_e'(op))
            ALU_ADD: begin
                w_wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, sc};
                w_res  = w_wide[W-1:0];
                w_bit  = w_wide[W];
            end
            ALU_SUB: begin
                // Top bit of the widened difference is the unsigned borrow.
                w_wide = {1'b0, a} - {1'b0, b};
                w_res  = w_wide[W-1:0];
                w_bit  = w_wide[W];
            end
            ALU_AND:   w_res = a & b;
            ALU_OR:    w_res = a | b;
            ALU_XOR:   w_res = a ^ b;
            ALU_NOT:   w_res = ~a;
            ALU_SHL: begin
                w_res = {a[W-2:0], sc};
                w_bit = a[W-1];
            end
            ALU_SHR: begin
                w_res = {sc, a[W-1:1]};
                w_bit = a[0];
            end
            ALU_GETB:  w_bit = a[imm];
            ALU_SETB: begin
                w_res[imm] = sc;
                w_bit      = sc;
            end
            ALU_PASSB: w_res = b;
            ALU_INC: begin
                w_wide = {1'b0, a} + {{W{1'b0}}, 1'b1};
                w_res  = w_wide[W-1:0];
                w_bit  = w_wide[W];
            end
            default: begin
                w_res = a;
                w_bit = 1'b0;
            end
        endcase
    end

    assign out     = w_res;
    assign zero    = (w_res == '0);
    assign parity  = ^w_res;
    assign out_bit = w_bit;

endmodule : alu_core
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// exec_unit : execute-stage slice - ALU, carry/bit storage, address counter
// Revision : 1.0
// ============================================================================
module exec_unit
    import exec_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  wire logic Clk,
    input  wire logic Reset,
    exec_if.slave     bus
);

    logic [W-1:0] r_ctr;
    logic         r_bit;
    logic         w_sc;
    logic         w_bit_next;
    logic [W-1:0] w_out;
    logic         w_zero;
    logic         w_parity;
    logic         w_out_bit;

    // Stored bit feeds back only through the register: no same-cycle bypass.
    assign w_sc = bus.ScSel ? 1'b0 : r_bit;

    alu_core #(.W(W)) u_alu (
        .a       (bus.InputA),
        .b       (bus.InputB),
        .imm     (bus.imm),
        .op      (bus.AluOp),
        .sc      (w_sc),
        .out     (w_out),
        .zero    (w_zero),
        .parity  (w_parity),
        .out_bit (w_out_bit)
    );

    always_comb begin
        w_bit_next = 1'b0;
        case (bit_sel_e'(bus.BitSel))
            BIT_PARITY: w_bit_next = w_parity;
            BIT_OUTBIT: w_bit_next = w_out_bit;
            default:    w_bit_next = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bit <= 1'b0;
        end else if (bus.BitWrEn) begin
            r_bit <= w_bit_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ctr <= '0;
        end else if (bus.CtrWrEn) begin
            r_ctr <= w_out;
        end else if (bus.CtrInc) begin
            r_ctr <= r_ctr + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.Out    = w_out;
    assign bus.Zero   = w_zero;
    assign bus.Parity = w_parity;
    assign bus.OutBit = w_out_bit;
    assign bus.CtrOut = r_ctr;
    assign bus.BitOut = r_bit;

endmodule : exec_unit
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// ============================================================================
// tb_exec_unit : directed self-checking bench for exec_unit
// Revision : 1.0
// ============================================================================
module tb_exec_unit;
    import exec_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    exec_if #(.W(8)) bus ();

    exec_unit #(.W(8)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] imm, input logic sc_sel);
        bus.AluOp  = op;
        bus.InputA = a;
        bus.InputB = b;
        bus.imm    = imm;
        bus.ScSel  = sc_sel;
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.BitWrEn = 1'b1;
        bus.BitSel  = BIT_PARITY;
        bus.CtrWrEn = 1'b1;
        bus.CtrInc  = 1'b0;
        drive(ALU_PASSB, 8'h00, 8'h01, 3'd0, 1'b0);
        check("reset_comb_out", bus.Out, 8'h01);
        tick();
        check("reset_ctr", bus.CtrOut, 8'h00);
        check("reset_bit", {7'd0, bus.BitOut}, 8'h00);
        rst         = 1'b0;
        bus.CtrWrEn = 1'b0;

        // XOR with parity capture sets the stored bit
        bus.BitSel = BIT_PARITY;
        drive(ALU_XOR, 8'h0F, 8'h01, 3'd0, 1'b0);
        check("xor_out", bus.Out, 8'h0E);
        check("xor_parity", {7'd0, bus.Parity}, 8'h01);
        tick();
        check("bit_from_parity", {7'd0, bus.BitOut}, 8'h01);
        bus.BitWrEn = 1'b0;

        drive(ALU_ADD, 8'hF0, 8'h20, 3'd0, 1'b0);
        check("add_sc1_out", bus.Out, 8'h11);
        check("add_sc1_carry", {7'd0, bus.OutBit}, 8'h01);
        check("add_sc1_zero", {7'd0, bus.Zero}, 8'h00);
        check("add_sc1_parity", {7'd0, bus.Parity}, 8'h00);
        drive(ALU_ADD, 8'hF0, 8'h20, 3'd0, 1'b1);
        check("add_sc0_out", bus.Out, 8'h10);

        drive(ALU_SUB, 8'h05, 8'h05, 3'd0, 1'b0);
        check("sub_eq_out", bus.Out, 8'h00);
        check("sub_eq_zero", {7'd0, bus.Zero}, 8'h01);
        check("sub_eq_parity", {7'd0, bus.Parity}, 8'h00);
        check("sub_eq_borrow", {7'd0, bus.OutBit}, 8'h00);
        drive(ALU_SUB, 8'h03, 8'h05, 3'd0, 1'b0);
        check("sub_lt_out", bus.Out, 8'hFE);
        check("sub_lt_borrow", {7'd0, bus.OutBit}, 8'h01);

        // Constant-zero source clears the bit, visible only after the edge
        bus.BitWrEn = 1'b1;
        bus.BitSel  = BIT_ZERO;
        drive(ALU_ADD, 8'h00, 8'h00, 3'd0, 1'b0);
        check("no_bypass_out", bus.Out, 8'h01);
        tick();
        check("bit_cleared", {7'd0, bus.BitOut}, 8'h00);

        bus.BitSel = BIT_OUTBIT;
        drive(ALU_GETB, 8'b0010_0000, 8'h00, 3'd5, 1'b0);
        check("getb_out", bus.Out, 8'h20);
        check("getb_bit", {7'd0, bus.OutBit}, 8'h01);
        tick();
        check("bit_from_getb", {7'd0, bus.BitOut}, 8'h01);
        bus.BitWrEn = 1'b0;

        drive(ALU_SHL, 8'h81, 8'h00, 3'd0, 1'b0);
        check("shl_out", bus.Out, 8'h03);
        check("shl_bit", {7'd0, bus.OutBit}, 8'h01);
        drive(ALU_SHR, 8'h81, 8'h00, 3'd0, 1'b0);
        check("shr_out", bus.Out, 8'hC0);
        check("shr_bit", {7'd0, bus.OutBit}, 8'h01);
        drive(ALU_SETB, 8'h00, 8'h00, 3'd3, 1'b0);
        check("setb_out", bus.Out, 8'h08);
        check("setb_bit", {7'd0, bus.OutBit}, 8'h01);
        drive(ALU_SETB, 8'hFF, 8'h00, 3'd6, 1'b1);
        check("setb_clr_out", bus.Out, 8'hBF);
        drive(ALU_AND, 8'hCC, 8'hAA, 3'd0, 1'b0);
        check("and_out", bus.Out, 8'h88);
        drive(ALU_OR, 8'hCC, 8'hAA, 3'd0, 1'b0);
        check("or_out", bus.Out, 8'hEE);
        drive(ALU_NOT, 8'h0F, 8'h00, 3'd0, 1'b0);
        check("not_out", bus.Out, 8'hF0);
        drive(ALU_INC, 8'hFF, 8'h00, 3'd0, 1'b0);
        check("inc_wrap_out", bus.Out, 8'h00);
        check("inc_wrap_carry", {7'd0, bus.OutBit}, 8'h01);
        check("inc_wrap_zero", {7'd0, bus.Zero}, 8'h01);
        drive(ALU_RSV1, 8'h5A, 8'h00, 3'd0, 1'b0);
        check("rsv_out", bus.Out, 8'h5A);
        check("rsv_bit", {7'd0, bus.OutBit}, 8'h00);

        // Counter load, increment with wrap, and load-over-increment priority
        bus.CtrWrEn = 1'b1;
        drive(ALU_PASSB, 8'h00, 8'hFE, 3'd0, 1'b0);
        tick();
        check("ctr_load", bus.CtrOut, 8'hFE);
        bus.CtrWrEn = 1'b0;
        bus.CtrInc  = 1'b1;
        tick();
        check("ctr_inc_ff", bus.CtrOut, 8'hFF);
        tick();
        check("ctr_inc_wrap", bus.CtrOut, 8'h00);
        bus.CtrWrEn = 1'b1;
        drive(ALU_PASSB, 8'h00, 8'h10, 3'd0, 1'b0);
        tick();
        check("ctr_load_prio", bus.CtrOut, 8'h10);
        bus.CtrInc = 1'b0;
        drive(ALU_INC, bus.CtrOut, 8'h00, 3'd0, 1'b0);
        tick();
        check("ctr_feedback", bus.CtrOut, 8'h11);
        bus.CtrWrEn = 1'b0;
        tick();
        check("ctr_hold", bus.CtrOut, 8'h11);

        rst         = 1'b1;
        bus.CtrInc  = 1'b1;
        bus.BitWrEn = 1'b1;
        bus.BitSel  = BIT_OUTBIT;
        drive(ALU_GETB, 8'hFF, 8'h00, 3'd0, 1'b0);
        tick();
        check("reset_wins_ctr", bus.CtrOut, 8'h00);
        check("reset_wins_bit", {7'd0, bus.BitOut}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_exec_unit
`default_nettype wire
